// File: rtl/issue_dispatch_queue_pkg.sv
// Shared types for the issue/dispatch queue: operation codes, decode record,
// optype classification and the RV32I decoder used on the queue head.
package issue_dispatch_queue_pkg;

    localparam int unsigned RegW    = 5;
    localparam logic [RegW-1:0] RegZero = '0;

    // Loads and stores are contiguous so that is_ls is a simple range test.
    typedef enum logic [5:0] {
        OpNop, OpLui, OpAuipc, OpJal, OpJalr,
        OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu,
        OpLb, OpLh, OpLw, OpLbu, OpLhu, OpSb, OpSh, OpSw,
        OpAddi, OpSlti, OpSltiu, OpXori, OpOri, OpAndi, OpSlli, OpSrli, OpSrai,
        OpAdd, OpSub, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpSra, OpOr, OpAnd
    } optype_e;

    typedef struct packed {
        optype_e         optype;
        logic [RegW-1:0] rd;
        logic [RegW-1:0] rs1;
        logic [RegW-1:0] rs2;
        logic [31:0]     imm;
    } decode_t;

    function automatic logic is_ls(input optype_e op);
        return (op >= OpLb) && (op <= OpSw);
    endfunction

    function automatic logic is_branch(input optype_e op);
        return (op >= OpBeq) && (op <= OpBgeu);
    endfunction

    function automatic logic is_store(input optype_e op);
        return (op >= OpSb) && (op <= OpSw);
    endfunction

    function automatic logic has_rd(input optype_e op);
        return (op != OpNop) && !is_branch(op) && !is_store(op);
    endfunction

    function automatic logic uses_rs1(input optype_e op);
        return (op != OpNop) && (op != OpLui) && (op != OpAuipc) && (op != OpJal);
    endfunction

    function automatic logic uses_rs2(input optype_e op);
        return is_branch(op) || is_store(op) || (op >= OpAdd);
    endfunction

    // Unrecognised encodings decode to OpNop with a zero immediate.
    function automatic decode_t decode_instr(input logic [31:0] ins);
        decode_t     d;
        logic [2:0]  f3;
        logic        alt;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
        f3    = ins[14:12];
        alt   = ins[30];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        imm_b = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_u = {ins[31:12], 12'b0};
        imm_j = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        shamt = {27'b0, ins[24:20]};
        d.optype = OpNop;
        d.rd     = ins[11:7];
        d.rs1    = ins[19:15];
        d.rs2    = ins[24:20];
        d.imm    = '0;
        case (ins[6:0])
            7'b0110111: begin d.optype = OpLui;   d.imm = imm_u; end
            7'b0010111: begin d.optype = OpAuipc; d.imm = imm_u; end
            7'b1101111: begin d.optype = OpJal;   d.imm = imm_j; end
            7'b1100111: begin d.optype = OpJalr;  d.imm = imm_i; end
            7'b1100011: begin
                d.imm = imm_b;
                case (f3)
                    3'b000:  d.optype = OpBeq;
                    3'b001:  d.optype = OpBne;
                    3'b100:  d.optype = OpBlt;
                    3'b101:  d.optype = OpBge;
                    3'b110:  d.optype = OpBltu;
                    3'b111:  d.optype = OpBgeu;
                    default: d.imm = '0;
                endcase
            end
            7'b0000011: begin
                d.imm = imm_i;
                case (f3)
                    3'b000:  d.optype = OpLb;
                    3'b001:  d.optype = OpLh;
                    3'b010:  d.optype = OpLw;
                    3'b100:  d.optype = OpLbu;
                    3'b101:  d.optype = OpLhu;
                    default: d.imm = '0;
                endcase
            end
            7'b0100011: begin
                d.imm = imm_s;
                case (f3)
                    3'b000:  d.optype = OpSb;
                    3'b001:  d.optype = OpSh;
                    3'b010:  d.optype = OpSw;
                    default: d.imm = '0;
                endcase
            end
            7'b0010011: begin
                d.imm = imm_i;
                case (f3)
                    3'b000: d.optype = OpAddi;
                    3'b010: d.optype = OpSlti;
                    3'b011: d.optype = OpSltiu;
                    3'b100: d.optype = OpXori;
                    3'b110: d.optype = OpOri;
                    3'b111: d.optype = OpAndi;
                    3'b001: begin d.optype = OpSlli; d.imm = shamt; end
                    default: begin
                        if (alt) d.optype = OpSrai;
                        else     d.optype = OpSrli;
                        d.imm = shamt;
                    end
                endcase
            end
            7'b0110011: begin
                case (f3)
                    3'b000: begin
                        if (alt) d.optype = OpSub;
                        else     d.optype = OpAdd;
                    end
                    3'b001: d.optype = OpSll;
                    3'b010: d.optype = OpSlt;
                    3'b011: d.optype = OpSltu;
                    3'b100: d.optype = OpXor;
                    3'b110: d.optype = OpOr;
                    3'b111: d.optype = OpAnd;
                    default: begin
                        if (alt) d.optype = OpSra;
                        else     d.optype = OpSrl;
                    end
                endcase
            end
            default: d.optype = OpNop;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/issue_dispatch_queue_iq_fifo.sv
// Instruction FIFO for the dispatch queue: Depth entries, synchronous reset and flush,
// head visible combinationally.
module issue_dispatch_queue_iq_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [Width-1:0]         wdata_i,
    output logic [Width-1:0]         rdata_o,
    output logic [$clog2(Depth):0]   count_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign do_push = push_i & ~flush_i & (count_q != DepthCnt);
    assign do_pop  = pop_i & ~flush_i & (count_q != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PtrW'(1);
            if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: count gates every read of a stale entry.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/issue_dispatch_queue.sv
// Issue/dispatch queue: buffers fetched instructions, decodes the head, resolves operands
// from regfile/ROB/CDB, renames rd and dispatches one instruction per cycle to RS or LSB.
module issue_dispatch_queue
    import issue_dispatch_queue_pkg::*;
#(
    parameter int unsigned Depth  = 4,
    parameter int unsigned TagW   = 5,
    parameter int unsigned NumCdb = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   rdy_i,
    input  logic                   flush_i,
    input  logic                   fet_valid_i,
    input  logic [31:0]            fet_instr_i,
    input  logic [31:0]            fet_pc_i,
    output logic                   iq_full_o,
    input  logic                   rob_full_i,
    input  logic [TagW-1:0]        rob_new_tag_i,
    output logic                   rob_alloc_o,
    output logic [4:0]             rs1_2reg_o,
    output logic [4:0]             rs2_2reg_o,
    input  logic [TagW-1:0]        reg_q1_i,
    input  logic [TagW-1:0]        reg_q2_i,
    input  logic [31:0]            reg_v1_i,
    input  logic [31:0]            reg_v2_i,
    input  logic                   rob_q1_rdy_i,
    input  logic                   rob_q2_rdy_i,
    input  logic [31:0]            rob_v1_i,
    input  logic [31:0]            rob_v2_i,
    input  logic [NumCdb-1:0]      cdb_valid_i,
    input  logic [NumCdb*TagW-1:0] cdb_tag_i,
    input  logic [NumCdb*32-1:0]   cdb_val_i,
    output logic                   rename_en_o,
    output logic [4:0]             rename_rd_o,
    output logic [TagW-1:0]        rename_tag_o,
    input  logic                   rs_full_i,
    input  logic                   lsb_full_i,
    output logic                   ena_rs_o,
    output logic                   ena_lsb_o,
    output optype_e                dis_optype_o,
    output logic [TagW-1:0]        dis_qi_o,
    output logic [TagW-1:0]        dis_qj_o,
    output logic [31:0]            dis_vi_o,
    output logic [31:0]            dis_vj_o,
    output logic [31:0]            dis_imm_o,
    output logic [31:0]            dis_pc_o,
    output logic [4:0]             dis_rd_o,
    output logic [TagW-1:0]        dis_tag_o
);
    localparam int unsigned CntW = $clog2(Depth) + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [CntW-1:0] count;
    logic [63:0]     head;
    decode_t         dec;
    logic            head_ls, target_full, push, fire;

    issue_dispatch_queue_iq_fifo #(
        .Depth (Depth),
        .Width (64)
    ) u_iq_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (push),
        .pop_i   (fire),
        .wdata_i ({fet_pc_i, fet_instr_i}),
        .rdata_o (head),
        .count_o (count)
    );

    assign dec         = decode_instr(head[31:0]);
    assign head_ls     = is_ls(dec.optype);
    assign target_full = head_ls ? lsb_full_i : rs_full_i;

    assign iq_full_o = (count == DepthCnt);
    assign push      = rdy_i & fet_valid_i & ~iq_full_o & ~flush_i;
    assign fire      = rdy_i & ~flush_i & (count != '0) & ~rob_full_i & ~target_full;

    assign rob_alloc_o  = fire;
    assign rename_en_o  = fire & has_rd(dec.optype) & (dec.rd != RegZero);
    assign rename_rd_o  = dec.rd;
    assign rename_tag_o = rob_new_tag_i;
    assign rs1_2reg_o   = dec.rs1;
    assign rs2_2reg_o   = dec.rs2;

    logic [NumCdb-1:0] hit1, hit2;

    for (genvar k = 0; k < NumCdb; k++) begin : g_cdb1
        assign hit1[k] = cdb_valid_i[k] & (cdb_tag_i[k*TagW +: TagW] == reg_q1_i);
    end

    for (genvar k = 0; k < NumCdb; k++) begin : g_cdb2
        assign hit2[k] = cdb_valid_i[k] & (cdb_tag_i[k*TagW +: TagW] == reg_q2_i);
    end

    logic [31:0]     cdb_v1, cdb_v2, v1, v2;
    logic [TagW-1:0] q1, q2;

    // Scanning from the top down leaves the lowest matching channel in place.
    always_comb begin
        cdb_v1 = '0;
        cdb_v2 = '0;
        for (int k = int'(NumCdb) - 1; k >= 0; k--) begin
            if (hit1[k]) cdb_v1 = cdb_val_i[k*32 +: 32];
            if (hit2[k]) cdb_v2 = cdb_val_i[k*32 +: 32];
        end
    end

    always_comb begin
        q1 = '0;
        v1 = '0;
        if (!uses_rs1(dec.optype)) begin
            q1 = '0;
        end else if (reg_q1_i == '0) begin
            v1 = reg_v1_i;
        end else if (rob_q1_rdy_i) begin
            v1 = rob_v1_i;
        end else if (|hit1) begin
            v1 = cdb_v1;
        end else begin
            q1 = reg_q1_i;
        end
    end

    always_comb begin
        q2 = '0;
        v2 = '0;
        if (!uses_rs2(dec.optype)) begin
            q2 = '0;
        end else if (reg_q2_i == '0) begin
            v2 = reg_v2_i;
        end else if (rob_q2_rdy_i) begin
            v2 = rob_v2_i;
        end else if (|hit2) begin
            v2 = cdb_v2;
        end else begin
            q2 = reg_q2_i;
        end
    end

    logic            ena_rs_q, ena_lsb_q;
    optype_e         dis_optype_q;
    logic [TagW-1:0] dis_qi_q, dis_qj_q, dis_tag_q;
    logic [31:0]     dis_vi_q, dis_vj_q, dis_imm_q, dis_pc_q;
    logic [4:0]      dis_rd_q;

    // Strobes drop every cycle without a fire, so a paused pipe never repeats one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ena_rs_q     <= 1'b0;
            ena_lsb_q    <= 1'b0;
            dis_optype_q <= OpNop;
            dis_qi_q     <= '0;
            dis_qj_q     <= '0;
            dis_vi_q     <= '0;
            dis_vj_q     <= '0;
            dis_imm_q    <= '0;
            dis_pc_q     <= '0;
            dis_rd_q     <= '0;
            dis_tag_q    <= '0;
        end else begin
            ena_rs_q  <= fire & ~head_ls;
            ena_lsb_q <= fire & head_ls;
            if (fire) begin
                dis_optype_q <= dec.optype;
                dis_qi_q     <= q1;
                dis_qj_q     <= q2;
                dis_vi_q     <= v1;
                dis_vj_q     <= v2;
                dis_imm_q    <= dec.imm;
                dis_pc_q     <= head[63:32];
                dis_rd_q     <= has_rd(dec.optype) ? dec.rd : RegZero;
                dis_tag_q    <= rob_new_tag_i;
            end
        end
    end

    assign ena_rs_o     = ena_rs_q;
    assign ena_lsb_o    = ena_lsb_q;
    assign dis_optype_o = dis_optype_q;
    assign dis_qi_o     = dis_qi_q;
    assign dis_qj_o     = dis_qj_q;
    assign dis_vi_o     = dis_vi_q;
    assign dis_vj_o     = dis_vj_q;
    assign dis_imm_o    = dis_imm_q;
    assign dis_pc_o     = dis_pc_q;
    assign dis_rd_o     = dis_rd_q;
    assign dis_tag_o    = dis_tag_q;

endmodule

// File: tb/tb_issue_dispatch_queue.sv
// Bench for issue_dispatch_queue: queue-level reference model feeding a scoreboard,
// with a separate monitor checking every dispatch strobe.
module tb_issue_dispatch_queue;
    import issue_dispatch_queue_pkg::*;

    localparam int unsigned Depth  = 4;
    localparam int unsigned TagW   = 5;
    localparam int unsigned NumCdb = 2;

    typedef enum logic [2:0] {KAddi, KAdd, KLw, KSw, KBeq, KLui} kind_e;

    typedef struct packed {
        kind_e       kind;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm, pc;
    } rec_t;

    typedef struct packed {
        int          cyc;
        logic        ls;
        optype_e     op;
        logic [4:0]  qi, qj, rd, tag;
        logic [31:0] vi, vj, imm, pc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rdy, flush, fet_valid, rob_full, rs_full, lsb_full;
    logic [31:0] fet_instr, fet_pc, reg_v1, reg_v2, rob_v1, rob_v2;
    logic [TagW-1:0] rob_new_tag, reg_q1, reg_q2;
    logic rob_q1_rdy, rob_q2_rdy;
    logic [NumCdb-1:0] cdb_valid;
    logic [NumCdb*TagW-1:0] cdb_tag;
    logic [NumCdb*32-1:0] cdb_val;
    logic iq_full, rob_alloc, rename_en, ena_rs, ena_lsb;
    logic [4:0] rs1_2reg, rs2_2reg, rename_rd, dis_rd;
    logic [TagW-1:0] rename_tag, dis_qi, dis_qj, dis_tag;
    logic [31:0] dis_vi, dis_vj, dis_imm, dis_pc;
    optype_e dis_optype;

    issue_dispatch_queue #(.Depth(Depth), .TagW(TagW), .NumCdb(NumCdb)) dut (
        .clk_i(clk), .rst_i(rst), .rdy_i(rdy), .flush_i(flush),
        .fet_valid_i(fet_valid), .fet_instr_i(fet_instr), .fet_pc_i(fet_pc),
        .iq_full_o(iq_full), .rob_full_i(rob_full), .rob_new_tag_i(rob_new_tag),
        .rob_alloc_o(rob_alloc), .rs1_2reg_o(rs1_2reg), .rs2_2reg_o(rs2_2reg),
        .reg_q1_i(reg_q1), .reg_q2_i(reg_q2), .reg_v1_i(reg_v1), .reg_v2_i(reg_v2),
        .rob_q1_rdy_i(rob_q1_rdy), .rob_q2_rdy_i(rob_q2_rdy),
        .rob_v1_i(rob_v1), .rob_v2_i(rob_v2),
        .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_val_i(cdb_val),
        .rename_en_o(rename_en), .rename_rd_o(rename_rd), .rename_tag_o(rename_tag),
        .rs_full_i(rs_full), .lsb_full_i(lsb_full),
        .ena_rs_o(ena_rs), .ena_lsb_o(ena_lsb), .dis_optype_o(dis_optype),
        .dis_qi_o(dis_qi), .dis_qj_o(dis_qj), .dis_vi_o(dis_vi), .dis_vj_o(dis_vj),
        .dis_imm_o(dis_imm), .dis_pc_o(dis_pc), .dis_rd_o(dis_rd), .dis_tag_o(dis_tag)
    );

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    rec_t mq[$];
    exp_t sb[$];
    rec_t in_rec;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic k_ls(input kind_e k);
        return (k == KLw) || (k == KSw);
    endfunction
    function automatic logic k_rd(input kind_e k);
        return (k == KAddi) || (k == KAdd) || (k == KLw) || (k == KLui);
    endfunction
    function automatic logic k_rs1(input kind_e k);
        return k != KLui;
    endfunction
    function automatic logic k_rs2(input kind_e k);
        return (k == KAdd) || (k == KSw) || (k == KBeq);
    endfunction
    function automatic optype_e k_op(input kind_e k);
        case (k)
            KAddi:   return OpAddi;
            KAdd:    return OpAdd;
            KLw:     return OpLw;
            KSw:     return OpSw;
            KBeq:    return OpBeq;
            default: return OpLui;
        endcase
    endfunction

    function automatic logic [31:0] encode(input rec_t r);
        logic [31:0] i;
        i = r.imm;
        case (r.kind)
            KAddi:   return {i[11:0], r.rs1, 3'b000, r.rd, 7'b0010011};
            KAdd:    return {7'b0, r.rs2, r.rs1, 3'b000, r.rd, 7'b0110011};
            KLw:     return {i[11:0], r.rs1, 3'b010, r.rd, 7'b0000011};
            KSw:     return {i[11:5], r.rs2, r.rs1, 3'b010, i[4:0], 7'b0100011};
            KBeq:    return {i[12], i[10:5], r.rs2, r.rs1, 3'b000, i[4:1], i[11], 7'b1100011};
            default: return {i[31:12], r.rd, 7'b0110111};
        endcase
    endfunction

    function automatic rec_t mk(input kind_e k, input int rd, input int rs1, input int rs2,
                                input logic [31:0] imm, input logic [31:0] pc);
        rec_t r;
        r.kind = k; r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.imm = imm; r.pc = pc;
        return r;
    endfunction

    function automatic rec_t rand_rec();
        logic [31:0] x;
        logic [31:0] imm;
        kind_e       k;
        x = $urandom;
        k = kind_e'($urandom_range(0, 5));
        case (k)
            KAdd:    imm = '0;
            KBeq:    imm = {{19{x[12]}}, x[12:1], 1'b0};
            KLui:    imm = {x[31:12], 12'b0};
            default: imm = {{20{x[11]}}, x[11:0]};
        endcase
        return mk(k, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  imm, $urandom & 32'hffff_fffc);
    endfunction

    // Operand rule: ready regfile value, then ROB result, then lowest CDB hit, else wait.
    task automatic resolve(input logic uses, input logic [4:0] q, input logic [31:0] v,
                           input logic rr, input logic [31:0] rv,
                           output logic [4:0] oq, output logic [31:0] ov);
        oq = '0;
        ov = '0;
        if (!uses) return;
        if (q == 0) begin ov = v; return; end
        if (rr) begin ov = rv; return; end
        for (int k = 0; k < int'(NumCdb); k++) begin
            if (cdb_valid[k] && cdb_tag[k*TagW +: TagW] == q) begin
                ov = cdb_val[k*32 +: 32];
                return;
            end
        end
        oq = q;
    endtask

    task automatic step();
        rec_t h;
        exp_t e;
        logic full_m, push_m, fire_m, ren_m;
        @(negedge clk);
        h      = '0;
        full_m = (mq.size() == int'(Depth));
        push_m = rdy && fet_valid && !full_m && !flush;
        fire_m = 1'b0;
        if (mq.size() != 0) begin
            h      = mq[0];
            fire_m = rdy && !flush && !rob_full && (k_ls(h.kind) ? !lsb_full : !rs_full);
        end
        ren_m = fire_m && k_rd(h.kind) && (h.rd != 0);
        if (!rst) begin
            chk("iq_full", 32'(iq_full), 32'(full_m));
            chk("rob_alloc", 32'(rob_alloc), 32'(fire_m));
            chk("rename_en", 32'(rename_en), 32'(ren_m));
            if (ren_m) begin
                chk("rename_rd", 32'(rename_rd), 32'(h.rd));
                chk("rename_tag", 32'(rename_tag), 32'(rob_new_tag));
            end
            if (mq.size() != 0 && k_rs1(h.kind)) chk("rs1_2reg", 32'(rs1_2reg), 32'(h.rs1));
            if (mq.size() != 0 && k_rs2(h.kind)) chk("rs2_2reg", 32'(rs2_2reg), 32'(h.rs2));
            if (fire_m) begin
                e.cyc = cyc + 1;
                e.ls  = k_ls(h.kind);
                e.op  = k_op(h.kind);
                e.imm = h.imm;
                e.pc  = h.pc;
                e.rd  = k_rd(h.kind) ? h.rd : 5'd0;
                e.tag = rob_new_tag;
                resolve(k_rs1(h.kind), reg_q1, reg_v1, rob_q1_rdy, rob_v1, e.qi, e.vi);
                resolve(k_rs2(h.kind), reg_q2, reg_v2, rob_q2_rdy, rob_v2, e.qj, e.vj);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (fire_m) void'(mq.pop_front());
            if (push_m) mq.push_back(in_rec);
        end
        cyc++;
        #1;
    endtask

    task automatic check_dispatch();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_dispatch: got ena_rs=%0d ena_lsb=%0d expected none (cycle %0d)",
                     ena_rs, ena_lsb, cyc);
            return;
        end
        e = sb.pop_front();
        chk("dispatch_cycle", 32'(cyc), 32'(e.cyc));
        chk("ena_lsb", 32'(ena_lsb), 32'(e.ls));
        chk("ena_rs", 32'(ena_rs), 32'(!e.ls));
        chk("dis_optype", 32'(dis_optype), 32'(e.op));
        chk("dis_qi", 32'(dis_qi), 32'(e.qi));
        chk("dis_vi", dis_vi, e.vi);
        chk("dis_qj", 32'(dis_qj), 32'(e.qj));
        chk("dis_vj", dis_vj, e.vj);
        chk("dis_imm", dis_imm, e.imm);
        chk("dis_pc", dis_pc, e.pc);
        chk("dis_rd", 32'(dis_rd), 32'(e.rd));
        chk("dis_tag", 32'(dis_tag), 32'(e.tag));
    endtask

    always @(negedge clk) begin
        if (!rst && (ena_rs || ena_lsb)) check_dispatch();
    end

    task automatic push_rec(input rec_t r);
        in_rec    = r;
        fet_instr = encode(r);
        fet_pc    = r.pc;
        fet_valid = 1'b1;
        step();
        fet_valid = 1'b0;
    endtask

    task automatic clear_ops();
        reg_q1 = '0; reg_q2 = '0; reg_v1 = '0; reg_v2 = '0;
        rob_q1_rdy = 1'b0; rob_q2_rdy = 1'b0; rob_v1 = '0; rob_v2 = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; fet_valid = 1'b0; fet_instr = '0; fet_pc = '0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; rob_new_tag = 5'd3;
        in_rec = '0;
        clear_ops();
        repeat (2) step();
        rst = 1'b0;
        chk("reset_ena_rs", 32'(ena_rs), 32'd0);
        chk("reset_ena_lsb", 32'(ena_lsb), 32'd0);
        chk("reset_iq_full", 32'(iq_full), 32'd0);
        chk("reset_dis_imm", dis_imm, 32'd0);
        chk("reset_dis_tag", 32'(dis_tag), 32'd0);

        // ADDI x1,x0,5 at PC 0
        push_rec(mk(KAddi, 1, 0, 0, 32'd5, 32'h0));
        repeat (2) step();

        // LW x2,0(x1): operand from CDB channel 1, then waiting, then from ROB
        reg_q1 = 5'd3; cdb_valid = 2'b10; cdb_tag = {5'd3, 5'd0}; cdb_val = {32'h1000, 32'h0};
        push_rec(mk(KLw, 2, 1, 0, 32'd0, 32'h4));
        repeat (2) step();
        cdb_valid = '0;
        push_rec(mk(KLw, 2, 1, 0, 32'd0, 32'h8));
        repeat (2) step();
        rob_q1_rdy = 1'b1; rob_v1 = 32'd7;
        push_rec(mk(KLw, 2, 1, 0, 32'd0, 32'hc));
        repeat (2) step();
        clear_ops();

        // Fill while RS is full; fifth push must be dropped
        rs_full = 1'b1;
        for (int i = 0; i < 5; i++) push_rec(mk(KAddi, i + 1, 0, 0, 32'(i), 32'(16 + 4 * i)));
        step();
        rs_full = 1'b0;
        repeat (6) step();

        // Flush with three queued and a push in the same cycle
        rs_full = 1'b1;
        for (int i = 0; i < 3; i++) push_rec(mk(KAdd, i + 4, 1, 2, 32'd0, 32'(64 + 4 * i)));
        flush = 1'b1;
        in_rec = mk(KAddi, 9, 0, 0, 32'd9, 32'h100);
        fet_instr = encode(in_rec); fet_pc = in_rec.pc; fet_valid = 1'b1;
        step();
        flush = 1'b0; fet_valid = 1'b0; rs_full = 1'b0;
        repeat (4) step();

        // Pause mid-stream
        rs_full = 1'b1;
        for (int i = 0; i < 4; i++) push_rec(mk(KAddi, i + 10, 0, 0, 32'(i), 32'(128 + 4 * i)));
        rs_full = 1'b0;
        step();
        rdy = 1'b0;
        repeat (3) step();
        rdy = 1'b1;
        repeat (5) step();

        for (int i = 0; i < 600; i++) begin
            rdy   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 9) < 6) begin
                in_rec = rand_rec();
                fet_instr = encode(in_rec); fet_pc = in_rec.pc; fet_valid = 1'b1;
            end else begin
                fet_valid = 1'b0;
            end
            rob_full    = ($urandom_range(0, 9) == 0);
            rs_full     = ($urandom_range(0, 4) == 0);
            lsb_full    = ($urandom_range(0, 4) == 0);
            rob_new_tag = 5'($urandom_range(1, 31));
            reg_q1      = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
            reg_q2      = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
            reg_v1      = $urandom; reg_v2 = $urandom;
            rob_q1_rdy  = ($urandom_range(0, 3) == 0);
            rob_q2_rdy  = ($urandom_range(0, 3) == 0);
            rob_v1      = $urandom; rob_v2 = $urandom;
            cdb_valid   = 2'($urandom_range(0, 3));
            cdb_tag     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            cdb_val     = {$urandom, $urandom};
            step();
        end

        rdy = 1'b1; flush = 1'b0; fet_valid = 1'b0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        repeat (Depth + 4) step();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
